// File: rtl/beamformer_n.sv
// Pipelined NN-channel signed dot product (multipliers + registered adder tree) with an optional LSB drop.
// Build option: define BF_ROUND_EN to round half up before the LSB drop instead of flooring.
module beamformer_n #(
  parameter int unsigned NN           = 4,
  parameter int unsigned a_width      = 8,
  parameter int unsigned b_width      = 8,
  parameter int unsigned BFO_width    = 18,
  parameter int unsigned out_drop_lsb = 0
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        we,
  input  logic [NN*a_width-1:0]       argsA,
  input  logic [NN*b_width-1:0]       argsB,
  output logic signed [BFO_width-1:0] bf_out
);

  localparam int unsigned LV = $clog2(NN);
  localparam int unsigned PW = a_width + b_width;
  localparam int unsigned W  = PW + LV;

  // Number of operands alive at a given tree level.
  function automatic int unsigned node_cnt(input int unsigned lvl);
    int unsigned c;
    c = NN;
    for (int unsigned j = 0; j < lvl; j++) begin
      c = (c + 1) / 2;
    end
    return c;
  endfunction

  // Level 0 holds the products; level k holds sums one bit wider than level k-1.
  for (genvar k = 0; k <= LV; k++) begin : g_lvl
    localparam int unsigned CW = PW + k;
    localparam int unsigned CN = node_cnt(k);

    logic signed [CW-1:0] node_d [CN];
    logic signed [CW-1:0] node_q [CN];

    if (k == 0) begin : g_mul
      for (genvar i = 0; i < CN; i++) begin : g_ch
        assign node_d[i] = CW'($signed(argsA[i*a_width +: a_width]))
                         * CW'($signed(argsB[i*b_width +: b_width]));
      end
    end else begin : g_add
      localparam int unsigned PN = node_cnt(k - 1);
      for (genvar i = 0; i < CN; i++) begin : g_node
        if (2*i + 1 < PN) begin : g_pair
          assign node_d[i] = CW'(g_lvl[k-1].node_q[2*i]) + CW'(g_lvl[k-1].node_q[2*i+1]);
        end else begin : g_pass
          // Odd leftover is re-registered so every path has the same depth.
          assign node_d[i] = CW'(g_lvl[k-1].node_q[2*i]);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!resetn) begin
        node_q <= '{default: '0};
      end else if (we) begin
        node_q <= node_d;
      end
    end
  end

  logic signed [W-1:0]         sum;
  logic signed [W:0]           pre;
  logic signed [BFO_width-1:0] bf_d;
  logic signed [BFO_width-1:0] bf_q;

  assign sum = g_lvl[LV].node_q[0];

`ifdef BF_ROUND_EN
  // Half an output LSB; zero when nothing is dropped.
  localparam logic signed [W:0] RND = ((W+1)'(1) << out_drop_lsb) >> 1;
  assign pre = (W+1)'(sum) + RND;
`else
  assign pre = (W+1)'(sum);
`endif

  // Arithmetic shift floors; the resize sign-extends or wraps to the output width.
  assign bf_d = BFO_width'(pre >>> out_drop_lsb);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      bf_q <= '0;
    end else if (we) begin
      bf_q <= bf_d;
    end
  end

  assign bf_out = bf_q;

endmodule

// File: tb/tb_beamformer_n.sv
// Scoreboard bench for beamformer_n: four parameterisations driven with directed and random vectors.
module tb_beamformer_n;

  localparam int NI = 4;
  localparam int P_NN   [NI] = '{4, 3, 4, 1};
  localparam int P_AW   [NI] = '{8, 6, 8, 8};
  localparam int P_BW   [NI] = '{8, 5, 8, 8};
  localparam int P_BFO  [NI] = '{18, 8, 16, 20};
  localparam int P_DROP [NI] = '{0, 2, 3, 0};
  localparam int P_LAT  [NI] = '{4, 4, 4, 2};

  logic clk;
  logic resetn;
  logic we;

  logic [31:0] a0, b0, a2, b2;
  logic [17:0] a1;
  logic [14:0] b1;
  logic [7:0]  a3, b3;

  logic signed [17:0] o0;
  logic signed [7:0]  o1;
  logic signed [15:0] o2;
  logic signed [19:0] o3;

  int av [NI][4];
  int bv [NI][4];
  longint exp_q [NI][$];

  int n_chk  = 0;
  int n_pass = 0;

  beamformer_n #(.NN(4), .a_width(8), .b_width(8), .BFO_width(18), .out_drop_lsb(0)) u0 (
    .clk(clk), .resetn(resetn), .we(we), .argsA(a0), .argsB(b0), .bf_out(o0));
  beamformer_n #(.NN(3), .a_width(6), .b_width(5), .BFO_width(8), .out_drop_lsb(2)) u1 (
    .clk(clk), .resetn(resetn), .we(we), .argsA(a1), .argsB(b1), .bf_out(o1));
  beamformer_n #(.NN(4), .a_width(8), .b_width(8), .BFO_width(16), .out_drop_lsb(3)) u2 (
    .clk(clk), .resetn(resetn), .we(we), .argsA(a2), .argsB(b2), .bf_out(o2));
  beamformer_n #(.NN(1), .a_width(8), .b_width(8), .BFO_width(20), .out_drop_lsb(0)) u3 (
    .clk(clk), .resetn(resetn), .we(we), .argsA(a3), .argsB(b3), .bf_out(o3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Random signed value of width w, biased towards the extremes.
  function automatic int rnd_s(input int w);
    int unsigned sel;
    sel = $urandom_range(7, 0);
    if (sel == 0) return -(1 << (w - 1));
    if (sel == 1) return (1 << (w - 1)) - 1;
    return int'($urandom_range((1 << w) - 1, 0)) - (1 << (w - 1));
  endfunction

  // Expected output: exact dot product, optional half-LSB bias, floor shift, wrap to output width.
  function automatic longint model(input int k);
    longint s;
    longint m;
    s = 0;
    for (int i = 0; i < P_NN[k]; i++) s += longint'(av[k][i]) * longint'(bv[k][i]);
`ifdef BF_ROUND_EN
    if (P_DROP[k] > 0) s += longint'(1) << (P_DROP[k] - 1);
`endif
    s = s >>> P_DROP[k];
    m = longint'(1) << P_BFO[k];
    s = s & (m - 1);
    if (s >= m / 2) s -= m;
    return s;
  endfunction

  task automatic gen(input int mode);
    for (int k = 0; k < NI; k++)
      for (int i = 0; i < 4; i++) begin
        av[k][i] = (i < P_NN[k]) ? rnd_s(P_AW[k]) : 0;
        bv[k][i] = (i < P_NN[k]) ? rnd_s(P_BW[k]) : 0;
      end
    for (int i = 0; i < 4; i++) begin
      case (mode)
        1: begin av[0][i] = 1;    bv[0][i] = i + 1; end
        2: begin av[0][i] = -128; bv[0][i] = -128;  end
        3: begin av[0][i] = 127;  bv[0][i] = -128;  end
        default: ;
      endcase
      if (mode != 0) begin
        av[2][i] = av[0][i];
        bv[2][i] = bv[0][i];
      end
    end
    for (int i = 0; i < 3; i++) begin
      case (mode)
        1: begin av[1][i] = (i == 0) ? -13 : 0; bv[1][i] = (i == 0) ? 1 : 0; end
        2: begin av[1][i] = -32; bv[1][i] = -16; end
        3: begin av[1][i] = 31;  bv[1][i] = -16; end
        default: ;
      endcase
    end
    case (mode)
      1: begin av[3][0] = -128; bv[3][0] = -128; end
      2: begin av[3][0] = 127;  bv[3][0] = -128; end
      default: ;
    endcase
    for (int i = 0; i < 4; i++) begin
      a0[i*8 +: 8] = 8'(av[0][i]);
      b0[i*8 +: 8] = 8'(bv[0][i]);
      a2[i*8 +: 8] = 8'(av[2][i]);
      b2[i*8 +: 8] = 8'(bv[2][i]);
    end
    for (int i = 0; i < 3; i++) begin
      a1[i*6 +: 6] = 6'(av[1][i]);
      b1[i*5 +: 5] = 5'(bv[1][i]);
    end
    a3 = 8'(av[3][0]);
    b3 = 8'(bv[3][0]);
  endtask

  // Drive one cycle of stimulus and record what each instance must eventually produce.
  task automatic step(input bit rst_v, input bit we_v, input int mode);
    @(negedge clk);
    resetn = rst_v;
    we     = we_v;
    gen(mode);
    for (int k = 0; k < NI; k++) begin
      if (!rst_v) begin
        exp_q[k].delete();
        for (int j = 0; j < P_LAT[k] - 1; j++) exp_q[k].push_back(0);
      end else if (we_v) begin
        exp_q[k].push_back(model(k));
      end
    end
  endtask

  // Monitor: one comparison per instance after every clock edge.
  initial begin
    longint last [NI];
    logic signed [63:0] got [NI];
    longint e;
    bit r, w;
    for (int k = 0; k < NI; k++) last[k] = 0;
    forever begin
      @(posedge clk);
      r = resetn;
      w = we;
      #1;
      got[0] = 64'(o0);
      got[1] = 64'(o1);
      got[2] = 64'(o2);
      got[3] = 64'(o3);
      for (int k = 0; k < NI; k++) begin
        n_chk++;
        if (!r) begin
          e = 0;
          last[k] = 0;
        end else if (w) begin
          if (exp_q[k].size() == 0) begin
            $display("FAIL scoreboard_underflow inst=%0d t=%0t", k, $time);
            continue;
          end
          e = exp_q[k].pop_front();
          last[k] = e;
        end else begin
          e = last[k];
        end
        if (got[k] !== e)
          $display("FAIL bf_out inst=%0d t=%0t rst=%0b we=%0b got=%0d expected=%0d",
                   k, $time, r, w, got[k], e);
        else
          n_pass++;
      end
    end
  end

  initial begin
    resetn = 1'b0;
    we     = 1'b0;
    gen(0);
    for (int k = 0; k < NI; k++)
      for (int j = 0; j < P_LAT[k] - 1; j++) exp_q[k].push_back(0);

    repeat (2)  step(1'b0, 1'b1, 0);
    repeat (6)  step(1'b1, 1'b1, 1);
    repeat (3)  step(1'b1, 1'b1, 2);
    repeat (3)  step(1'b1, 1'b1, 3);
    repeat (40) step(1'b1, 1'b1, 0);
    repeat (3)  step(1'b1, 1'b0, 0);
    repeat (40) step(1'b1, 1'b1, 0);
    step(1'b0, 1'b1, 0);
    repeat (40) step(1'b1, 1'b1, 0);
    for (int c = 0; c < 300; c++)
      step(($urandom_range(49, 0) != 0), ($urandom_range(4, 0) != 0), 0);
    repeat (8)  step(1'b1, 1'b1, 0);
    @(negedge clk);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/beamformer_n.md
Name: beamformer_n

Overview:
Parameterised beamformer combiner for the CRPA (controlled reception pattern antenna) chain. Each clock it takes NN signed antenna samples and NN signed weight coefficients, forms the dot product sum(A_i*B_i), and outputs it through a fully pipelined multiplier plus adder tree. An optional LSB drop scales the result. It sits between the per-antenna sample path and downstream correlators.

Parameters:
NN, 4, number of antenna channels (>=1)
a_width, 8, signed sample width per channel
b_width, 8, signed coefficient width per channel
BFO_width, 18, output width; full-precision width is a_width+b_width+CLOG2(NN)
out_drop_lsb, 0, number of LSBs discarded from the full-precision sum before output

Ports:
clk  input  1  clock; all logic on rising edge
resetn  input  1  reset, synchronous, active-low
we  input  1  pipeline clock enable
argsA  input  NN*a_width  packed signed samples; channel i at [(i+1)*a_width-1 : i*a_width]
argsB  input  NN*b_width  packed signed coefficients; channel i at [(i+1)*b_width-1 : i*b_width]
bf_out  output  BFO_width  signed beamformer output

Behaviour:
- Reset is synchronous, active-low, with clock clk. While resetn=0 on a clock edge, every pipeline register and bf_out is cleared to 0. Reset has priority over we.
- Stage 1: register the NN products P_i = A_i*B_i, signed, a_width+b_width bits each, exact.
- Stages 2..CLOG2(NN)+1: registered binary adder tree. Each level sign-extends its operands by 1 bit. An odd operand count passes the leftover operand through a register to keep alignment. Full sum width is W = a_width+b_width+CLOG2(NN) and never overflows.
- Final stage: register bf_out = (sum >>> out_drop_lsb), an arithmetic (floor) shift. The result is then sign-extended or truncated (low bits kept, wrap) to BFO_width.
- Latency is L = CLOG2(NN)+2 enabled clocks from inputs to bf_out. NN=1 gives L=2.
- we=1: all stages advance. we=0: all registers hold, inputs are ignored, and bf_out stays constant. There is no valid/ready handshake. With we tied high, a new result appears every cycle.
- Reset mid-stream flushes all in-flight results. After resetn returns high, bf_out is 0 for L-1 cycles, then tracks the new inputs.
- Inputs are sampled every enabled clock. The block places no constraint on input stability.
- Extremes: all A_i=-2^(a_width-1) and all B_i=-2^(b_width-1) gives NN*2^(a_width+b_width-2). This is exact when BFO_width >= W.

Optional Feature:
BF_ROUND_EN
- Defined: the final stage adds 2^(out_drop_lsb-1) to the full sum before the arithmetic shift (round half up). This applies only when out_drop_lsb>0; the add width is W+1 so it cannot overflow.
- Undefined: truncation (floor) as described above.
- With out_drop_lsb=0 both builds behave identically.

Test Plan:
- Defaults, we=1: A=(1,1,1,1), B=(1,2,3,4) held -> bf_out=10 exactly 4 cycles after the first sampling edge; 0 before that.
- Defaults: all A=-128, all B=-128 -> bf_out=65536; A=(127,127,127,127), B=(-128,...) -> -65024; no wrap.
- Defaults, streaming a new random vector each cycle -> bf_out equals the golden dot product delayed by 4 cycles, every cycle.
- we held 0 for 3 cycles mid-stream -> bf_out frozen; resumes with no lost or duplicated samples after we=1.
- resetn=0 for 1 cycle mid-stream -> bf_out=0 on the next edge and for 3 cycles after release, then the new sums.
- out_drop_lsb=2, sum=-13 -> bf_out=-4 without BF_ROUND_EN, -3 with it; sum=65536 and out_drop_lsb=3 -> 8192 in both builds.
